// File: rtl/int_to_rec_float_pipe.sv
// int_to_rec_float_pipe
// Three-stage integer to HardFloat recoded-float (recFN) converter with
// valid/ready flow control and a flush input.
//   S1: sign/magnitude split and leading-zero count
//   S2: normalise; split into significand, round bit and sticky bit
//   S3: round, pack, inexact flag
// Ports:
//   clock, reset (async, active-low), kill (drops every in-flight op)
//   in_valid/in_ready, in_int, in_signed, in_rm, in_tag    : request side
//   out_valid/out_ready, out_rec, out_flags, out_tag       : result side
// Parameters must satisfy 2^(EXP_W-1) > IN_W, so overflow is impossible and
// only NX can ever be raised.
module int_to_rec_float_pipe #(
  parameter int IN_W  = 64,
  parameter int EXP_W = 8,
  parameter int SIG_W = 24
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   kill,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [IN_W-1:0]        in_int,
  input  logic                   in_signed,
  input  logic [2:0]             in_rm,
  input  logic [4:0]             in_tag,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+SIG_W:0]   out_rec,
  output logic [4:0]             out_flags,
  output logic [4:0]             out_tag
);

  localparam int LZ_W  = $clog2(IN_W) + 1;
  localparam int REC_W = EXP_W + SIG_W + 1;
  // normalised operand followed by enough zero padding that the significand,
  // round and sticky slices exist for every legal IN_W/SIG_W combination
  localparam int EXT_W = IN_W + SIG_W + 2;

  // pipeline valids and flow control
  logic s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
  logic s1_free, s2_free, s3_free;
  logic s1_load, s2_load, s3_load;

  // S1 registers
  logic              s1_neg_q, s1_neg_d, s1_neg_n;
  logic [IN_W-1:0]   s1_mag_q, s1_mag_d, s1_mag_n;
  logic [LZ_W-1:0]   s1_lz_q, s1_lz_d, s1_lz_n;
  logic [2:0]        s1_rm_q, s1_rm_d;
  logic [4:0]        s1_tag_q, s1_tag_d;

  // S2 registers
  logic              s2_neg_q, s2_neg_d;
  logic              s2_zero_q, s2_zero_d;
  logic [SIG_W-1:0]  s2_sig_q, s2_sig_d;
  logic [EXP_W:0]    s2_e_q, s2_e_d;
  logic              s2_r_q, s2_r_d;
  logic              s2_s_q, s2_s_d;
  logic [2:0]        s2_rm_q, s2_rm_d;
  logic [4:0]        s2_tag_q, s2_tag_d;
  logic [IN_W-1:0]   s2_norm_n;
  logic [EXT_W-1:0]  s2_ext_n;

  // S3 registers
  logic [REC_W-1:0]  s3_rec_q, s3_rec_d, s3_rec_n;
  logic              s3_nx_q, s3_nx_d;
  logic [4:0]        s3_tag_q, s3_tag_d;
  logic              s3_inc_n;
  logic [SIG_W:0]    s3_sum_n;
  logic [EXP_W:0]    s3_e_n;
  logic              unused_hidden;

  // A stage may take new data when it is empty or its content moves on this
  // cycle; this chains combinationally from out_ready back to in_ready.
  always_comb begin
    s3_free    = ~s3_valid_q | out_ready;
    s2_free    = ~s2_valid_q | s3_free;
    s1_free    = ~s1_valid_q | s2_free;
    in_ready   = s1_free | kill;
    s1_load    = s1_free & in_valid;
    s2_load    = s2_free & s1_valid_q;
    s3_load    = s3_free & s2_valid_q;
    s1_valid_d = s1_free ? in_valid   : s1_valid_q;
    s2_valid_d = s2_free ? s1_valid_q : s2_valid_q;
    s3_valid_d = s3_free ? s2_valid_q : s3_valid_q;
    if (kill) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
      s3_valid_d = 1'b0;
    end
  end

  // S1: magnitude wraps for the most-negative input and is read as unsigned
  always_comb begin
    s1_neg_n = in_signed & in_int[IN_W-1];
    s1_mag_n = s1_neg_n ? (IN_W'(0) - in_int) : in_int;
    s1_lz_n  = LZ_W'(IN_W);
    for (int i = 0; i < IN_W; i++) begin
      if (s1_mag_n[i]) s1_lz_n = LZ_W'(IN_W - 1 - i);
    end
    s1_neg_d = s1_load ? s1_neg_n : s1_neg_q;
    s1_mag_d = s1_load ? s1_mag_n : s1_mag_q;
    s1_lz_d  = s1_load ? s1_lz_n  : s1_lz_q;
    s1_rm_d  = s1_load ? in_rm    : s1_rm_q;
    s1_tag_d = s1_load ? in_tag   : s1_tag_q;
  end

  // S2: exponent is meaningless for a zero operand; the zero flag overrides it
  always_comb begin
    s2_norm_n = s1_mag_q << s1_lz_q;
    s2_ext_n  = {s2_norm_n, {(SIG_W + 2){1'b0}}};
    s2_neg_d  = s2_load ? s1_neg_q : s2_neg_q;
    s2_zero_d = s2_load ? (s1_mag_q == '0) : s2_zero_q;
    s2_sig_d  = s2_load ? s2_ext_n[EXT_W-1 -: SIG_W] : s2_sig_q;
    s2_r_d    = s2_load ? s2_ext_n[EXT_W-1-SIG_W] : s2_r_q;
    s2_s_d    = s2_load ? (|s2_ext_n[EXT_W-2-SIG_W:0]) : s2_s_q;
    s2_e_d    = s2_load ? ((EXP_W+1)'(IN_W - 1) - (EXP_W+1)'(s1_lz_q)) : s2_e_q;
    s2_rm_d   = s2_load ? s1_rm_q  : s2_rm_q;
    s2_tag_d  = s2_load ? s1_tag_q : s2_tag_q;
  end

  // S3: on significand carry-out the low bits are already zero, so only the
  // exponent needs bumping.
  always_comb begin
    case (s2_rm_q)
      3'd1:    s3_inc_n = 1'b0;
      3'd2:    s3_inc_n = s2_neg_q & (s2_r_q | s2_s_q);
      3'd3:    s3_inc_n = ~s2_neg_q & (s2_r_q | s2_s_q);
      3'd4:    s3_inc_n = s2_r_q;
      default: s3_inc_n = s2_r_q & (s2_s_q | s2_sig_q[0]);
    endcase
    s3_sum_n      = {1'b0, s2_sig_q} + {{SIG_W{1'b0}}, s3_inc_n};
    unused_hidden = s3_sum_n[SIG_W-1];
    s3_e_n        = s2_e_q + {{EXP_W{1'b0}}, s3_sum_n[SIG_W]};
    s3_rec_n      = {s2_neg_q, s3_e_n + {1'b1, {EXP_W{1'b0}}}, s3_sum_n[SIG_W-2:0]};
    if (s2_zero_q) s3_rec_n = '0;
    s3_rec_d = s3_load ? s3_rec_n : s3_rec_q;
    s3_nx_d  = s3_load ? ((s2_r_q | s2_s_q) & ~s2_zero_q) : s3_nx_q;
    s3_tag_d = s3_load ? s2_tag_q : s3_tag_q;
  end

  // result outputs read as zero whenever no result is held (including reset)
  always_comb begin
    out_valid = s3_valid_q;
    out_rec   = s3_valid_q ? s3_rec_q : '0;
    out_flags = {4'b0000, s3_valid_q & s3_nx_q};
    out_tag   = s3_valid_q ? s3_tag_q : 5'd0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s3_valid_q <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s3_valid_q <= s3_valid_d;
    end
  end

  always_ff @(posedge clock) begin
    s1_neg_q  <= s1_neg_d;
    s1_mag_q  <= s1_mag_d;
    s1_lz_q   <= s1_lz_d;
    s1_rm_q   <= s1_rm_d;
    s1_tag_q  <= s1_tag_d;
    s2_neg_q  <= s2_neg_d;
    s2_zero_q <= s2_zero_d;
    s2_sig_q  <= s2_sig_d;
    s2_e_q    <= s2_e_d;
    s2_r_q    <= s2_r_d;
    s2_s_q    <= s2_s_d;
    s2_rm_q   <= s2_rm_d;
    s2_tag_q  <= s2_tag_d;
    s3_rec_q  <= s3_rec_d;
    s3_nx_q   <= s3_nx_d;
    s3_tag_q  <= s3_tag_d;
  end

endmodule

// File: tb/tb_int_to_rec_float_pipe.sv
// Bench for int_to_rec_float_pipe at IN_W=64, EXP_W=8, SIG_W=24.
module tb_int_to_rec_float_pipe;

  logic        clock = 1'b0;
  logic        reset, kill, in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [63:0] in_int;
  logic [2:0]  in_rm;
  logic [4:0]  in_tag, out_flags, out_tag;
  logic [32:0] out_rec;
  int          n_pass = 0;
  int          n_total = 0;

  always #5 clock = ~clock;

  int_to_rec_float_pipe #(.IN_W(64), .EXP_W(8), .SIG_W(24)) dut (
    .clock(clock), .reset(reset), .kill(kill),
    .in_valid(in_valid), .in_ready(in_ready), .in_int(in_int),
    .in_signed(in_signed), .in_rm(in_rm), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_rec(out_rec),
    .out_flags(out_flags), .out_tag(out_tag)
  );

  // Reference: value-level rounding of |x| to a 24-bit significand by
  // comparing the discarded remainder against half an ulp.
  // Returns {rec[32:0], flags[4:0]}.
  function automatic logic [37:0] model(input logic [63:0] v, input logic sg, input logic [2:0] rm);
    logic        neg, up;
    logic [63:0] mag, q, rem, half;
    int          e, sh;
    neg = sg && v[63];
    mag = neg ? -v : v;
    if (mag == 64'd0) return '0;
    e = 0;
    for (int i = 0; i < 64; i++) if (mag[i]) e = i;
    rem = 64'd0;
    half = 64'd0;
    if (e <= 23) q = mag << (23 - e);
    else begin
      sh   = e - 23;
      q    = mag >> sh;
      rem  = mag - (q << sh);
      half = 64'd1 << (sh - 1);
    end
    up = 1'b0;
    if (rem != 64'd0) begin
      case (rm)
        3'd1:    up = 1'b0;
        3'd2:    up = neg;
        3'd3:    up = !neg;
        3'd4:    up = (rem >= half);
        default: up = (rem > half) || (rem == half && q[0]);
      endcase
    end
    q = q + {63'd0, up};
    if (q == (64'd1 << 24)) begin
      q = 64'd1 << 23;
      e = e + 1;
    end
    return {neg, 9'(e + 256), q[22:0], 4'b0000, rem != 64'd0};
  endfunction

  function automatic logic [63:0] rand_int();
    logic [63:0] v;
    int          sh;
    v = {$urandom, $urandom};
    case ($urandom_range(0, 4))
      0: v = v >> $urandom_range(0, 63);
      1: v = 64'd1 << $urandom_range(0, 63);
      2: v = ~(v >> $urandom_range(1, 63));
      3: begin
        sh = int'($urandom_range(1, 39));
        v  = (((v >> 40) | 64'h80_0000) << sh) | (64'd1 << (sh - 1));
      end
      default: ;
    endcase
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Issues one op into an empty pipe and collects its result; lat counts
  // edges from the accepting edge up to the edge that presents out_valid.
  task automatic run_op(input logic [63:0] v, input logic sg, input logic [2:0] rm,
                        input logic [4:0] tg, output logic [32:0] rec,
                        output logic [4:0] fl, output logic [4:0] otg, output int lat);
    in_int = v; in_signed = sg; in_rm = rm; in_tag = tg;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    rec = out_rec; fl = out_flags; otg = out_tag;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0; kill = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_int = '0; in_signed = 1'b0; in_rm = 3'd0; in_tag = 5'd0;
    #3;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_total++;
    if ({out_rec, out_flags, out_tag} !== 43'd0)
      $display("FAIL reset_outputs got %h/%h/%h want 0", out_rec, out_flags, out_tag);
    else n_pass++;
    repeat (2) @(posedge clock);
    #3;
    reset = 1'b1;
    step();
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_release_valid got %b want 0", out_valid); else n_pass++;
  endtask

  task automatic test_directed();
    logic [63:0] vals [9];
    logic        sgs  [9];
    logic [2:0]  rms  [9];
    logic [32:0] xr   [9];
    logic        xnx  [9];
    logic [32:0] rec;
    logic [4:0]  fl, tg;
    int          lat;
    vals = '{64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'h100_0001, 64'h100_0001,
             64'h100_0001, 64'h1FF_FFFF, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FEFF_FFFF};
    sgs  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    rms  = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd3, 3'd1, 3'd0, 3'd0, 3'd2};
    xr   = '{33'h0_8000_0000, 33'h1_8000_0000, 33'h0_0000_0000, 33'h0_8C00_0000,
             33'h0_8C00_0001, 33'h0_8C00_0000, 33'h0_8C80_0000, 33'h1_9F80_0000,
             33'h1_8C00_0001};
    xnx  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 9; i++) begin
      run_op(vals[i], sgs[i], rms[i], 5'(i + 3), rec, fl, tg, lat);
      n_total++;
      if (lat !== 3) $display("FAIL directed_latency[%0d] got %0d want 3", i, lat); else n_pass++;
      n_total++;
      if (rec !== xr[i]) $display("FAIL directed_rec[%0d] got %h want %h", i, rec, xr[i]); else n_pass++;
      n_total++;
      if (fl !== {4'b0000, xnx[i]}) $display("FAIL directed_flags[%0d] got %b want %b", i, fl, {4'b0000, xnx[i]});
      else n_pass++;
      n_total++;
      if (tg !== 5'(i + 3)) $display("FAIL directed_tag[%0d] got %0d want %0d", i, tg, i + 3); else n_pass++;
    end
  endtask

  task automatic test_random(input int n_ops);
    logic [42:0] exp_q [$];
    logic [42:0] e;
    int          issued, cycles;
    issued = 0;
    cycles = 0;
    while ((issued < n_ops || exp_q.size() != 0) && cycles < 20000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      if (issued < n_ops && $urandom_range(0, 4) != 0) begin
        in_valid  = 1'b1;
        in_int    = rand_int();
        in_signed = 1'($urandom_range(0, 1));
        in_rm     = 3'($urandom_range(0, 7));
        in_tag    = issued[4:0];
      end else in_valid = 1'b0;
      #1;
      if (out_valid && out_ready) begin
        n_total++;
        if (exp_q.size() == 0) $display("FAIL random_spurious got tag %0d want no result", out_tag);
        else begin
          e = exp_q.pop_front();
          if ({out_tag, out_rec, out_flags} !== e)
            $display("FAIL random_result got %h/%h/%h want %h/%h/%h", out_tag, out_rec, out_flags,
                     e[42:38], e[37:5], e[4:0]);
          else n_pass++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back({in_tag, model(in_int, in_signed, in_rm)});
        issued++;
      end
      step();
      cycles++;
    end
    in_valid = 1'b0;
    n_total++;
    if (cycles >= 20000) $display("FAIL random_drain got %0d pending want 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_backpressure();
    logic [42:0] bp_exp [4];
    logic [32:0] hold_rec;
    logic [4:0]  hold_fl, hold_tag;
    int          got, cyc;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid  = 1'b1;
      in_int    = rand_int();
      in_signed = 1'($urandom_range(0, 1));
      in_rm     = 3'($urandom_range(0, 4));
      in_tag    = 5'(10 + i);
      bp_exp[i] = {in_tag, model(in_int, in_signed, in_rm)};
      if (i < 3) begin
        #1;
        n_total++;
        if (in_ready !== 1'b1) $display("FAIL bp_ready_accept[%0d] got %b want 1", i, in_ready); else n_pass++;
        step();
      end
    end
    #1;
    n_total++;
    if (in_ready !== 1'b0) $display("FAIL bp_ready_full got %b want 0", in_ready); else n_pass++;
    n_total++;
    if ({out_valid, out_tag, out_rec, out_flags} !== {1'b1, bp_exp[0]})
      $display("FAIL bp_head got %b/%h/%h/%h want 1/%h", out_valid, out_tag, out_rec, out_flags, bp_exp[0]);
    else n_pass++;
    hold_rec = out_rec; hold_fl = out_flags; hold_tag = out_tag;
    for (int k = 0; k < 5; k++) begin
      step();
      n_total++;
      if ({in_ready, out_valid, out_rec, out_flags, out_tag} !== {1'b0, 1'b1, hold_rec, hold_fl, hold_tag})
        $display("FAIL bp_hold[%0d] got %b/%b/%h/%h/%h want 0/1/%h/%h/%h", k, in_ready, out_valid,
                 out_rec, out_flags, out_tag, hold_rec, hold_fl, hold_tag);
      else n_pass++;
    end
    out_ready = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL bp_ready_release got %b want 1", in_ready); else n_pass++;
    got = 0;
    cyc = 0;
    while (got < 4 && cyc < 20) begin
      if (out_valid) begin
        n_total++;
        if ({out_tag, out_rec, out_flags} !== bp_exp[got])
          $display("FAIL bp_order[%0d] got %h/%h/%h want %h", got, out_tag, out_rec, out_flags, bp_exp[got]);
        else n_pass++;
        got++;
      end
      step();
      in_valid = 1'b0;
      cyc++;
    end
    n_total++;
    if (got !== 4) $display("FAIL bp_count got %0d want 4", got); else n_pass++;
  endtask

  task automatic test_kill();
    logic [32:0] rec, xr;
    logic [4:0]  fl, tg;
    int          lat;
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_int = rand_int(); in_signed = 1'b0; in_rm = 3'd0; in_tag = 5'(20 + i);
      step();
    end
    in_tag = 5'd22;
    kill = 1'b1;
    #1;
    n_total++;
    if (in_ready !== 1'b1) $display("FAIL kill_in_ready got %b want 1", in_ready); else n_pass++;
    step();
    kill = 1'b0;
    in_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL kill_drop[%0d] got %b want 0", k, out_valid); else n_pass++;
      step();
    end
    in_int = rand_int();
    xr = model(in_int, 1'b1, 3'd3) >> 5;
    run_op(in_int, 1'b1, 3'd3, 5'd23, rec, fl, tg, lat);
    n_total++;
    if ({lat, tg, rec} !== {32'd3, 5'd23, xr})
      $display("FAIL kill_next got lat %0d tag %0d rec %h want 3/23/%h", lat, tg, rec, xr);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [32:0] rec, xr;
    logic [4:0]  fl, tg;
    int          lat;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_int = rand_int(); in_signed = 1'b1; in_rm = 3'd4; in_tag = 5'(24 + i);
      step();
    end
    in_valid = 1'b0;
    #1;
    n_total++;
    if (out_valid !== 1'b1) $display("FAIL rst_mid_before got %b want 1", out_valid); else n_pass++;
    #2;
    reset = 1'b0;
    #1;
    n_total++;
    if ({out_valid, in_ready, out_rec, out_tag} !== {1'b0, 1'b1, 33'd0, 5'd0})
      $display("FAIL rst_mid_async got %b/%b/%h/%h want 0/1/0/0", out_valid, in_ready, out_rec, out_tag);
    else n_pass++;
    #3;
    reset = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (out_valid !== 1'b0) $display("FAIL rst_mid_after[%0d] got %b want 0", k, out_valid); else n_pass++;
      step();
    end
    in_int = rand_int();
    xr = model(in_int, 1'b0, 3'd2) >> 5;
    run_op(in_int, 1'b0, 3'd2, 5'd30, rec, fl, tg, lat);
    n_total++;
    if ({lat, tg, rec} !== {32'd3, 5'd30, xr})
      $display("FAIL rst_mid_next got lat %0d tag %0d rec %h want 3/30/%h", lat, tg, rec, xr);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random(300);
    test_backpressure();
    test_kill();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
